// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive frame buffer: accepts every TEMAC byte into a circular
// byte RAM, commits only good frames, and replays committed frames on an AXI4-Stream master.
module eth_rx_frame_buffer #(
  parameter int addr_width = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] overflow_count,
  output logic [31:0] bad_count
);

  localparam int DEPTH = 1 << addr_width;
  localparam int PW    = addr_width + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{addr_width{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_FULL = {1'b1, {addr_width{1'b0}}};

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_RECV   = 2'd1,
    ST_DROP   = 2'd2
  } in_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [8:0]    mem_q [DEPTH];
  in_state_e     state_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_commit_q;
  logic [PW-1:0] rd_ptr_q;
  logic [31:0]   ovf_cnt_q;
  logic [31:0]   bad_cnt_q;
  logic [7:0]    out_data_q;
  logic          out_last_q;
  logic          out_valid_q;

  logic [PW-1:0] used_s;
  logic          full_s;
  logic          wr_en_s;
  logic          avail_s;
  logic          load_s;

  // Full check uses registered pointers only, so space freed this cycle shows up next cycle.
  assign used_s  = wr_ptr_q - rd_ptr_q;
  assign full_s  = (used_s == PTR_FULL);
  assign wr_en_s = (state_q == ST_RECV) && s_axis_tvalid && !full_s;
  assign avail_s = (rd_ptr_q != wr_commit_q);
  assign load_s  = !out_valid_q || m_axis_tready;

  // Byte RAM write port: {tlast, tdata} per entry.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[addr_width-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Input FSM: write pointer, commit pointer and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESYNC;
      wr_ptr_q    <= PTR_ZERO;
      wr_commit_q <= PTR_ZERO;
      ovf_cnt_q   <= 32'd0;
      bad_cnt_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_RESYNC: begin
          if (!s_axis_tvalid || s_axis_tlast) begin
            state_q <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (s_axis_tvalid) begin
            if (full_s) begin
              wr_ptr_q <= wr_commit_q;
              if (s_axis_tlast) begin
                ovf_cnt_q <= sat_inc(ovf_cnt_q);
              end else begin
                state_q <= ST_DROP;
              end
            end else if (s_axis_tlast && s_axis_tuser) begin
              wr_ptr_q  <= wr_commit_q;
              bad_cnt_q <= sat_inc(bad_cnt_q);
            end else if (s_axis_tlast) begin
              wr_ptr_q    <= wr_ptr_q + PTR_ONE;
              wr_commit_q <= wr_ptr_q + PTR_ONE;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
          end
        end
        ST_DROP: begin
          // tuser is deliberately ignored: an overflowed bad frame counts as overflow only.
          if (s_axis_tvalid && s_axis_tlast) begin
            ovf_cnt_q <= sat_inc(ovf_cnt_q);
            state_q   <= ST_RECV;
          end
        end
        default: begin
          state_q <= ST_RESYNC;
        end
      endcase
    end
  end

  // Read port doubles as the output register; it reloads whenever empty or being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      rd_ptr_q    <= PTR_ZERO;
    end else if (load_s) begin
      if (avail_s) begin
        {out_last_q, out_data_q} <= mem_q[rd_ptr_q[addr_width-1:0]];
        out_valid_q              <= 1'b1;
        rd_ptr_q                 <= rd_ptr_q + PTR_ONE;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata   = out_data_q;
  assign m_axis_tlast   = out_last_q;
  assign m_axis_tvalid  = out_valid_q;
  assign m_axis_tuser   = 1'b0;
  assign overflow_count = ovf_cnt_q;
  assign bad_count      = bad_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Self-checking bench for eth_rx_frame_buffer: frame-level reference model (expected byte
// queue plus drop counters) driven by directed and randomized frames.
module tb_eth_rx_frame_buffer;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] overflow_count;
  logic [31:0] bad_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [8:0] exp_q[$];
  int pend_ovf = 0;
  int pend_bad = 0;
  int exp_ovf = 0;
  int exp_bad = 0;
  bit chk_en = 1'b0;
  bit stall_prev = 1'b0;
  int rdy_mode = 1;

  eth_rx_frame_buffer #(.addr_width(AW)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .overflow_count(overflow_count),
    .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counter model: a drop decided during the tlast cycle becomes visible after the next edge.
  always @(posedge clk) begin
    if (rst) begin
      pend_ovf = 0;
      pend_bad = 0;
      exp_ovf  = 0;
      exp_bad  = 0;
    end else begin
      exp_ovf = pend_ovf;
      exp_bad = pend_bad;
    end
  end

  // Downstream ready pattern: 0 = stalled, 1 = always ready, otherwise 50% random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: every presented byte must be the head of the expected queue.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check_eq("overflow_count", overflow_count, exp_ovf);
      check_eq("bad_count", bad_count, exp_bad);
      if (stall_prev) check_eq("valid_held", m_axis_tvalid, 64'd1);
      if (m_axis_tvalid) begin
        check_eq("tuser", m_axis_tuser, 64'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", m_axis_tvalid, 64'd0);
        end else begin
          check_eq("out_byte", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
          if (m_axis_tready) void'(exp_q.pop_front());
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  // base < 0 selects random data; rst_at >= 0 pulses reset during that byte.
  task automatic send_frame(input int len, input bit bad, input int base, input int rst_at);
    logic [8:0] frame_q[$];
    logic [7:0] d;
    bit ovf;
    ovf = (exp_q.size() + len > DEPTH);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      frame_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, d});
      if (i == rst_at) begin
        rst = 1'b1;
        exp_q.delete();
      end else begin
        rst = 1'b0;
      end
    end
    if (rst_at < 0) begin
      if (ovf) pend_ovf++;
      else if (bad) pend_bad++;
      else foreach (frame_q[j]) exp_q.push_back(frame_q[j]);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 64'd0);
    idle(3);
  endtask

  initial begin
    int len;
    int n;
    // Reset values
    rdy_mode = 1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", m_axis_tvalid, 64'd0);
    check_eq("rst_tlast", m_axis_tlast, 64'd0);
    check_eq("rst_tdata", m_axis_tdata, 64'd0);
    check_eq("rst_tuser", m_axis_tuser, 64'd0);
    check_eq("rst_ovf", overflow_count, 64'd0);
    check_eq("rst_bad", bad_count, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Single 64-byte frame: first tvalid exactly two cycles after input tlast, no gaps
    idle(1);
    send_frame(64, 1'b0, 0, -1);
    @(negedge clk);
    check_eq("lat_n0", m_axis_tvalid, 64'd0);
    idle(1);
    @(negedge clk);
    check_eq("lat_n1", m_axis_tvalid, 64'd0);
    @(negedge clk);
    check_eq("lat_n2", m_axis_tvalid, 64'd1);
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      check_eq("no_gap", m_axis_tvalid, 64'd1);
    end
    @(negedge clk);
    check_eq("after_frame", m_axis_tvalid, 64'd0);

    // Bad frame between two good ones, back to back
    send_frame(60, 1'b0, 8'h10, -1);
    send_frame(80, 1'b1, 8'h20, -1);
    send_frame(60, 1'b0, 8'h30, -1);
    wait_drain();

    // Overflow while stalled, then oversized and exactly-full frames alone
    rdy_mode = 0;
    idle(2);
    send_frame(1500, 1'b0, 8'h01, -1);
    send_frame(1500, 1'b0, 8'h02, -1);
    idle(5);
    rdy_mode = 1;
    wait_drain();
    send_frame(DEPTH + 1, 1'b0, 8'h03, -1);
    wait_drain();
    send_frame(DEPTH, 1'b0, 8'h04, -1);
    wait_drain();
    send_frame(DEPTH + 1, 1'b1, 8'h05, -1);
    wait_drain();

    // Random backpressure with random-length frames, throttled to stay within the buffer
    rdy_mode = 2;
    for (int f = 0; f < 16; f++) begin
      len = $urandom_range(60, 1514);
      n = 0;
      while (exp_q.size() + len + 16 > DEPTH && n < 40000) begin
        idle(1);
        n++;
      end
      check_eq("throttle", (n < 40000) ? 64'd1 : 64'd0, 64'd1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_frame(len, 1'b0, -1, -1);
    end
    wait_drain();

    // Reset with a pending stalled transfer
    rdy_mode = 0;
    send_frame(30, 1'b0, 8'h40, -1);
    idle(4);
    @(negedge clk);
    check_eq("pend_valid", m_axis_tvalid, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst2_tvalid", m_axis_tvalid, 64'd0);
    check_eq("rst2_tdata", m_axis_tdata, 64'd0);
    check_eq("rst2_tlast", m_axis_tlast, 64'd0);
    rdy_mode = 1;
    idle(10);

    // Reset during byte 20 of a 100-byte frame, then a clean frame after a gap
    send_frame(100, 1'b0, 8'h50, 20);
    idle(8);
    send_frame(64, 1'b0, 8'h80, -1);
    wait_drain();

    // Pointer wrap: many short frames back to back
    for (int f = 0; f < 120; f++) send_frame(50, 1'b0, f, -1);
    wait_drain();
    check_eq("wrap_ovf", overflow_count, 64'd0);

    idle(5);
    @(negedge clk);
    check_eq("final_idle", m_axis_tvalid, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
